branch_flush_ctrl: RTL and testbench

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

---
 rtl/branch_flush_ctrl_pkg.sv | 22 ++
 rtl/branch_flush_ctrl_sat_counter16.sv | 20 ++
 rtl/branch_flush_ctrl.sv | 98 +++++++++
 tb/tb_branch_flush_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/branch_flush_ctrl_pkg.sv
// Shared pipeline definitions for the branch flush controller: state encoding,
// counter width and the delay-slot nullify rule.
package branch_flush_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    NULL_DS = 1'b1
  } state_t;

  function automatic logic calc_taken(input logic j, input logic uncond);
    return uncond | j;
  endfunction

  // Forward taken and backward not-taken branches with N set squash the delay slot.
  function automatic logic calc_nullify(input logic n, input logic taken,
                                        input logic uncond, input logic disp_neg);
    return n & ((taken & (uncond | ~disp_neg)) | (~taken & ~uncond & disp_neg));
  endfunction

endpackage

// File: rtl/branch_flush_ctrl_sat_counter16.sv
// Event counter with enable and synchronous increment that holds at all-ones
// instead of wrapping.
module sat_counter16
  import branch_flush_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch redirect and delay-slot squash control for the EX stage, with
// saturating statistics for taken branches and nullified delay slots.
//
//   state   | meaning
//   IDLE    | no squash pending; a branch in EX may be accepted
//   NULL_DS | delay-slot instruction in ID is being squashed; branches ignored
module branch_flush_ctrl
  import branch_flush_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BR_VALID,
  input  logic             J,
  input  logic             UNCOND,
  input  logic             N,
  input  logic             DISP_NEG,
  input  logic [31:0]      TA,
  input  logic             STALL,
  output logic             PC_SEL,
  output logic [31:0]      TA_OUT,
  output logic             NULLIFY_DS,
  output logic [CNT_W-1:0] TAKEN_CNT,
  output logic [CNT_W-1:0] NULL_CNT
);

  state_t      state_q;
  state_t      state_nxt;
  logic        taken;
  logic        nullify;
  logic        accept;
  logic        inc_taken;
  logic        inc_null;
  logic        pc_sel_nxt;
  logic [31:0] ta_nxt;

  assign taken   = calc_taken(J, UNCOND);
  assign nullify = calc_nullify(N, taken, UNCOND, DISP_NEG);
  assign accept  = BR_VALID & ~STALL & (state_q == IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      PC_SEL     <= 1'b0;
      TA_OUT     <= 32'h0;
      NULLIFY_DS <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      PC_SEL     <= pc_sel_nxt;
      TA_OUT     <= ta_nxt;
      NULLIFY_DS <= (state_nxt == NULL_DS);
    end
  end

  always_comb begin
    state_nxt  = state_q;
    // A pending redirect survives a stall so the fetch unit cannot miss it.
    pc_sel_nxt = PC_SEL & STALL;
    ta_nxt     = TA_OUT;
    inc_taken  = 1'b0;
    inc_null   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (taken) begin
            pc_sel_nxt = 1'b1;
            ta_nxt     = TA;
            inc_taken  = 1'b1;
          end
          if (nullify) begin
            state_nxt = NULL_DS;
            inc_null  = 1'b1;
          end
        end
      end
      NULL_DS: begin
        if (!STALL) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter16 u_taken_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (inc_taken),
    .cnt   (TAKEN_CNT)
  );

  sat_counter16 u_null_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (inc_null),
    .cnt   (NULL_CNT)
  );

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Self-checking bench for branch_flush_ctrl: directed scenarios, randomized
// traffic against a behavioural model, counter saturation and async reset.
module tb_branch_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic        j = 1'b0;
  logic        uncond = 1'b0;
  logic        n = 1'b0;
  logic        disp_neg = 1'b0;
  logic [31:0] ta = 32'h0;
  logic        stall = 1'b0;
  logic        pc_sel;
  logic [31:0] ta_out;
  logic        nullify_ds;
  logic [15:0] taken_cnt;
  logic [15:0] null_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a pending redirect, a pending squash, and event totals.
  bit          m_squash;
  bit          m_redirect;
  logic [31:0] m_target;
  int          m_taken_total;
  int          m_null_total;

  branch_flush_ctrl dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .BR_VALID   (br_valid),
    .J          (j),
    .UNCOND     (uncond),
    .N          (n),
    .DISP_NEG   (disp_neg),
    .TA         (ta),
    .STALL      (stall),
    .PC_SEL     (pc_sel),
    .TA_OUT     (ta_out),
    .NULLIFY_DS (nullify_ds),
    .TAKEN_CNT  (taken_cnt),
    .NULL_CNT   (null_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_squash      = 0;
    m_redirect    = 0;
    m_target      = 32'h0;
    m_taken_total = 0;
    m_null_total  = 0;
  endtask

  task automatic check_model();
    check("pc_sel", {31'b0, pc_sel}, {31'b0, m_redirect});
    check("ta_out", ta_out, m_target);
    check("nullify_ds", {31'b0, nullify_ds}, {31'b0, m_squash});
    check("taken_cnt", {16'b0, taken_cnt}, (m_taken_total > 65535) ? 32'hFFFF : 32'(m_taken_total));
    check("null_cnt", {16'b0, null_cnt}, (m_null_total > 65535) ? 32'hFFFF : 32'(m_null_total));
  endtask

  // Drive one cycle of inputs (clock low), predict, clock, then compare at negedge.
  task automatic cycle(input logic bv, input logic jj, input logic uc, input logic nn,
                       input logic dn, input logic [31:0] t, input logic st);
    bit go, tk, sq, nx_squash, nx_redirect;
    br_valid = bv; j = jj; uncond = uc; n = nn; disp_neg = dn; ta = t; stall = st;
    go = bv && !st && !m_squash;
    tk = uc || jj;
    if (tk) sq = nn && (uc || !dn);
    else    sq = nn && dn;
    nx_redirect = (go && tk) || (m_redirect && st);
    nx_squash   = m_squash ? st : (go && sq);
    @(posedge clk);
    m_redirect = nx_redirect;
    m_squash   = nx_squash;
    if (go && tk) begin
      m_target = t;
      m_taken_total++;
    end
    if (go && sq) m_null_total++;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    br_valid = 0; j = 0; uncond = 0; n = 0; disp_neg = 0; ta = 0; stall = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_model();

    // Forward conditional taken with nullify
    cycle(1, 1, 0, 1, 0, 32'h0000_0100, 0);
    check("fwd_pc_sel", {31'b0, pc_sel}, 32'h1);
    check("fwd_ta_out", ta_out, 32'h100);
    check("fwd_nullify", {31'b0, nullify_ds}, 32'h1);
    check("fwd_cnts", {taken_cnt, null_cnt}, {16'd1, 16'd1});
    cycle(0, 0, 0, 0, 0, 32'h0, 0);

    // Backward conditional not taken, with and without N
    cycle(1, 0, 0, 1, 1, 32'h0000_0500, 0);
    check("bwd_nt_pc_sel", {31'b0, pc_sel}, 32'h0);
    check("bwd_nt_nullify", {31'b0, nullify_ds}, 32'h1);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    check("bwd_nt_nullify_drop", {31'b0, nullify_ds}, 32'h0);
    cycle(1, 0, 0, 0, 1, 32'h0000_0500, 0);
    check("bwd_nt_n0_nullify", {31'b0, nullify_ds}, 32'h0);

    // Unconditional backward branch
    cycle(1, 0, 1, 0, 1, 32'h0000_0040, 0);
    check("bl_pc_sel", {31'b0, pc_sel}, 32'h1);
    check("bl_ta_out", ta_out, 32'h40);
    check("bl_taken_cnt", {16'b0, taken_cnt}, 32'd2);

    // Stall holds redirect and squash; branch during squash is ignored
    cycle(1, 1, 0, 1, 0, 32'h0000_0200, 0);
    repeat (3) begin
      cycle(1, 1, 0, 0, 0, 32'h0000_0300, 1);
      check("stall_hold", {30'b0, pc_sel, nullify_ds}, 32'h3);
    end
    cycle(1, 1, 0, 0, 0, 32'h0000_0300, 0);
    check("stall_release", {30'b0, pc_sel, nullify_ds}, 32'h0);
    check("stall_ta_kept", ta_out, 32'h200);
    check("ignored_cnts", {taken_cnt, null_cnt}, {16'd3, 16'd3});

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset while squashing
    cycle(1, 1, 0, 1, 0, 32'h0000_0700, 0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    check("pre_reset_nullify", {31'b0, nullify_ds}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {30'b0, pc_sel, nullify_ds}, 32'h0);
    check("async_reset_ta", ta_out, 32'h0);
    check("async_reset_cnts", {taken_cnt, null_cnt}, 32'h0);
    model_reset();
    stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 32'h0, 0);

    // Saturation of the taken counter
    do_reset();
    repeat (65535) cycle(1, 1, 0, 0, 0, $urandom, 0);
    check("sat_reach", {16'b0, taken_cnt}, 32'hFFFF);
    cycle(1, 1, 0, 0, 0, 32'h1234_5678, 0);
    check("sat_hold", {16'b0, taken_cnt}, 32'hFFFF);
    check("sat_ta", ta_out, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
